// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the ARM pipeline hazard/forwarding controller: forwarding
// encodings, the scoreboard slot record and the memory-wait FSM states.
package arm_pipe_pkg;

    // Slot fields are sized for the largest supported configuration; narrower
    // register indices and operand counts are zero-extended into them.
    localparam int SB_ADDR_W_MAX = 8;
    localparam int SB_SRC_MAX    = 4;

    typedef logic [SB_ADDR_W_MAX-1:0] sb_addr_t;
    typedef logic [1:0]               fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'd0;
    localparam fwd_sel_t FWD_MEM = 2'd1;
    localparam fwd_sel_t FWD_WB  = 2'd2;

    typedef struct packed {
        logic                         valid;
        sb_addr_t                     dest;
        logic                         wb_en;
        logic                         mem_read;
        logic                         mem_acc;
        sb_addr_t [SB_SRC_MAX-1:0]    src;
        logic     [SB_SRC_MAX-1:0]    src_used;
    } sb_slot_t;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } pipe_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Control bundle between the datapath and pipeline_hazard_ctrl.
// Performance counter signals exist only when ARM_HAZARD_PERF_EN is defined.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 4,
    parameter int NUM_SRC    = 2,
    parameter int CNT_W      = 32
);
    logic                          forwarding_en;
    logic                          id_valid;
    logic [NUM_SRC*REG_ADDR_W-1:0] id_src;
    logic [NUM_SRC-1:0]            id_src_used;
    logic [REG_ADDR_W-1:0]         id_dest;
    logic                          id_wb_en;
    logic                          id_mem_read;
    logic                          id_mem_acc;
    logic                          branch_taken;
    logic                          mem_ready;
    logic                          freeze_front;
    logic                          flush_front;
    logic                          bubble_exe;
    logic                          stall_all;
    logic                          wb_bubble;
    logic [2*NUM_SRC-1:0]          fwd_sel;
    logic                          mem_timeout;
`ifdef ARM_HAZARD_PERF_EN
    logic [CNT_W-1:0]              perf_hazard_cycles;
    logic [CNT_W-1:0]              perf_mem_stall_cycles;
    logic [CNT_W-1:0]              perf_flushes;
`endif

    modport master (
`ifdef ARM_HAZARD_PERF_EN
        input  perf_hazard_cycles, perf_mem_stall_cycles, perf_flushes,
`endif
        output forwarding_en, id_valid, id_src, id_src_used, id_dest,
               id_wb_en, id_mem_read, id_mem_acc, branch_taken, mem_ready,
        input  freeze_front, flush_front, bubble_exe, stall_all, wb_bubble,
               fwd_sel, mem_timeout
    );

    modport slave (
`ifdef ARM_HAZARD_PERF_EN
        output perf_hazard_cycles, perf_mem_stall_cycles, perf_flushes,
`endif
        input  forwarding_en, id_valid, id_src, id_src_used, id_dest,
               id_wb_en, id_mem_read, id_mem_acc, branch_taken, mem_ready,
        output freeze_front, flush_front, bubble_exe, stall_all, wb_bubble,
               fwd_sel, mem_timeout
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_dep_cmp.sv
// pipe_dep_cmp: does one source operand depend on the result held in one slot?
module pipe_dep_cmp
    import arm_pipe_pkg::*;
(
    input  sb_addr_t src,
    input  logic     src_used,
    input  logic     slot_valid,
    input  logic     slot_wb_en,
    input  sb_addr_t slot_dest,
    output logic     hit
);
    assign hit = src_used & slot_valid & slot_wb_en & (src == slot_dest);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline control for the 5-stage ARM core: EXE/MEM/WB scoreboard, hazard
// freeze/flush/bubble, operand forwarding and variable-latency MEM wait FSM.
// Optional performance counters are built when ARM_HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl
    import arm_pipe_pkg::*;
#(
    parameter int REG_ADDR_W   = 4,
    parameter int NUM_SRC      = 2,
    parameter int MEM_WAIT_MAX = 255,
    parameter int CNT_W        = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int                WAIT_W     = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_WAIT_MAX);

    sb_slot_t           id_slot, exe_slot, mem_slot, wb_slot;
    pipe_state_t        state;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               timeout;
    logic [NUM_SRC-1:0] id_exe_hit, id_mem_hit, exe_mem_hit, exe_wb_hit, haz_src;
    logic               hazard, stall;
    logic               unused_slot_bits;

    always_comb begin
        id_slot          = '0;
        id_slot.valid    = 1'b1;
        id_slot.dest     = sb_addr_t'(bus.id_dest);
        id_slot.wb_en    = bus.id_wb_en;
        id_slot.mem_read = bus.id_mem_read;
        id_slot.mem_acc  = bus.id_mem_acc;
        for (int k = 0; k < NUM_SRC; k++) begin
            id_slot.src[k]      = sb_addr_t'(bus.id_src[k*REG_ADDR_W +: REG_ADDR_W]);
            id_slot.src_used[k] = bus.id_src_used[k];
        end
    end

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        pipe_dep_cmp u_id_exe (
            .src(id_slot.src[k]), .src_used(id_slot.src_used[k]),
            .slot_valid(exe_slot.valid), .slot_wb_en(exe_slot.wb_en),
            .slot_dest(exe_slot.dest), .hit(id_exe_hit[k]));
        pipe_dep_cmp u_id_mem (
            .src(id_slot.src[k]), .src_used(id_slot.src_used[k]),
            .slot_valid(mem_slot.valid), .slot_wb_en(mem_slot.wb_en),
            .slot_dest(mem_slot.dest), .hit(id_mem_hit[k]));
        pipe_dep_cmp u_exe_mem (
            .src(exe_slot.src[k]), .src_used(exe_slot.src_used[k]),
            .slot_valid(mem_slot.valid), .slot_wb_en(mem_slot.wb_en),
            .slot_dest(mem_slot.dest), .hit(exe_mem_hit[k]));
        pipe_dep_cmp u_exe_wb (
            .src(exe_slot.src[k]), .src_used(exe_slot.src_used[k]),
            .slot_valid(wb_slot.valid), .slot_wb_en(wb_slot.wb_en),
            .slot_dest(wb_slot.dest), .hit(exe_wb_hit[k]));

        // With forwarding only a load in EXE cannot be bypassed in time.
        assign haz_src[k] = bus.id_valid & (bus.forwarding_en
                          ? (id_exe_hit[k] & exe_slot.mem_read)
                          : (id_exe_hit[k] | id_mem_hit[k]));

        assign bus.fwd_sel[2*k +: 2] = !bus.forwarding_en ? FWD_RF
                                     : exe_mem_hit[k]     ? FWD_MEM
                                     : exe_wb_hit[k]      ? FWD_WB
                                     :                      FWD_RF;
    end

    assign hazard = |haz_src;
    assign stall  = mem_slot.valid & mem_slot.mem_acc & !bus.mem_ready;

    assign bus.stall_all    = stall;
    assign bus.wb_bubble    = stall;
    assign bus.freeze_front = stall | (hazard & !bus.branch_taken);
    assign bus.bubble_exe   = !stall & (hazard | bus.branch_taken);
    assign bus.flush_front  = bus.branch_taken & !stall;
    assign bus.mem_timeout  = timeout;

    // Only some slot fields feed decisions; the rest are kept for debug visibility.
    assign unused_slot_bits = ^{exe_slot, mem_slot, wb_slot};

    // ID -> EXE -> MEM -> WB scoreboard; a memory stall holds EXE/MEM and drains WB.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_slot <= '0;
            mem_slot <= '0;
            wb_slot  <= '0;
        end else if (stall) begin
            wb_slot <= '0;
        end else begin
            wb_slot  <= mem_slot;
            mem_slot <= exe_slot;
            exe_slot <= (bus.id_valid && !hazard && !bus.branch_taken) ? id_slot : '0;
        end
    end

    // Memory wait FSM; the counter saturates at the limit and the error is sticky.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (stall) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (bus.mem_ready) begin
                        state <= RUN;
                    end else begin
                        if (wait_cnt != WAIT_LIMIT) wait_cnt <= wait_cnt + WAIT_W'(1);
                        if (wait_cnt == WAIT_LIMIT - WAIT_W'(1)) timeout <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef ARM_HAZARD_PERF_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [CNT_W-1:0] perf_haz, perf_stall, perf_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_haz   <= '0;
            perf_stall <= '0;
            perf_flush <= '0;
        end else begin
            if (hazard && !bus.branch_taken && !stall) perf_haz <= sat_inc(perf_haz);
            if (stall)                                 perf_stall <= sat_inc(perf_stall);
            if (bus.flush_front)                       perf_flush <= sat_inc(perf_flush);
        end
    end

    assign bus.perf_hazard_cycles    = perf_haz;
    assign bus.perf_mem_stall_cycles = perf_stall;
    assign bus.perf_flushes          = perf_flush;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: per-cycle vector table through a
// scoreboard queue, plus an asynchronous reset taken in the middle of a memory wait.
module tb_pipeline_hazard_ctrl;

    typedef struct packed {
        logic       v;
        logic [3:0] s0;
        logic [3:0] s1;
        logic [1:0] used;
        logic [3:0] d;
        logic       wb;
        logic       rd;
        logic       acc;
    } instr_t;

    typedef struct {
        string      name;
        logic       fwd;
        instr_t     ins;
        logic       br;
        logic       rdy;
        logic [9:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    vec_t       vecs[$];
    logic [9:0] exp_q[$];
    string      name_q[$];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_ADDR_W(4), .NUM_SRC(2), .CNT_W(32)) bus ();

    pipeline_hazard_ctrl #(
        .REG_ADDR_W(4), .NUM_SRC(2), .MEM_WAIT_MAX(2), .CNT_W(32)
    ) dut (
        .clk(clk),
        .rst(rst_n),
        .bus(bus)
    );

    function automatic instr_t mki(input logic [3:0] s0, input logic [3:0] s1,
                                   input logic [1:0] used, input logic [3:0] d,
                                   input logic rd, input logic acc);
        instr_t i;
        i.v = 1'b1; i.s0 = s0; i.s1 = s1; i.used = used; i.d = d;
        i.wb = 1'b1; i.rd = rd; i.acc = acc;
        return i;
    endfunction

    // {freeze, flush, bubble, stall, wb_bubble, fwd_sel[op1], fwd_sel[op0], timeout}
    function automatic logic [9:0] ex(input logic f, input logic l, input logic b,
                                      input logic s, input logic w, input logic [1:0] f0,
                                      input logic [1:0] f1, input logic t);
        return {f, l, b, s, w, f1, f0, t};
    endfunction

    function automatic logic [9:0] outs();
        return {bus.freeze_front, bus.flush_front, bus.bubble_exe, bus.stall_all,
                bus.wb_bubble, bus.fwd_sel, bus.mem_timeout};
    endfunction

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic add(input string n, input logic fwd, input instr_t ins,
                       input logic br, input logic rdy, input logic [9:0] e);
        vec_t r;
        r.name = n; r.fwd = fwd; r.ins = ins; r.br = br; r.rdy = rdy; r.exp = e;
        vecs.push_back(r);
    endtask

    task automatic drive(input vec_t r);
        logic [9:0] e;
        string      n;
        @(posedge clk);
        #1;
        bus.forwarding_en = r.fwd;
        bus.id_valid      = r.ins.v;
        bus.id_src        = {r.ins.s1, r.ins.s0};
        bus.id_src_used   = r.ins.used;
        bus.id_dest       = r.ins.d;
        bus.id_wb_en      = r.ins.wb;
        bus.id_mem_read   = r.ins.rd;
        bus.id_mem_acc    = r.ins.acc;
        bus.branch_taken  = r.br;
        bus.mem_ready     = r.rdy;
        exp_q.push_back(r.exp);
        name_q.push_back(r.name);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_empty: got no entry required one");
        end else begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check(n, {22'b0, outs()}, {22'b0, e});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        instr_t NOP, ADD1, SUB2, ORR1, MOV1, AND7, LDR4, ADD5, ORR6;
        logic [9:0] Z, STL;
        vec_t r;

        NOP  = '0;
        ADD1 = mki(4'd2, 4'd3, 2'b11, 4'd1, 1'b0, 1'b0);
        SUB2 = mki(4'd1, 4'd3, 2'b11, 4'd2, 1'b0, 1'b0);
        ORR1 = mki(4'd1, 4'd6, 2'b11, 4'd1, 1'b0, 1'b0);
        MOV1 = mki(4'd9, 4'd2, 2'b01, 4'd1, 1'b0, 1'b0);
        AND7 = mki(4'd1, 4'd2, 2'b11, 4'd7, 1'b0, 1'b0);
        LDR4 = mki(4'd2, 4'd0, 2'b01, 4'd4, 1'b1, 1'b1);
        ADD5 = mki(4'd4, 4'd4, 2'b11, 4'd5, 1'b0, 1'b0);
        ORR6 = mki(4'd1, 4'd0, 2'b01, 4'd6, 1'b0, 1'b0);
        Z    = ex(0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        STL  = ex(1, 0, 0, 1, 1, 2'd0, 2'd0, 0);

        // forwarding: MEM and WB bypass, MEM priority, unused operand masked
        add("A1", 1, ADD1, 0, 1, Z);
        add("A2", 1, SUB2, 0, 1, Z);
        add("A3_fwd_mem", 1, ORR1, 0, 1, ex(0, 0, 0, 0, 0, 2'd1, 2'd0, 0));
        add("A4_fwd_wb", 1, MOV1, 0, 1, ex(0, 0, 0, 0, 0, 2'd2, 2'd0, 0));
        add("A5_unused_mask", 1, AND7, 0, 1, Z);
        add("A6_mem_prio", 1, NOP, 0, 1, ex(0, 0, 0, 0, 0, 2'd1, 2'd0, 0));
        add("A7", 1, NOP, 0, 1, Z);
        add("A8", 1, NOP, 0, 1, Z);
        // load-use with forwarding
        add("B1", 1, LDR4, 0, 1, Z);
        add("B2_load_use", 1, ADD5, 0, 1, ex(1, 0, 1, 0, 0, 2'd0, 2'd0, 0));
        add("B3", 1, ADD5, 0, 1, Z);
        add("B4_fwd_wb_both", 1, NOP, 0, 1, ex(0, 0, 0, 0, 0, 2'd2, 2'd2, 0));
        add("B5", 1, NOP, 0, 1, Z);
        add("B6", 1, NOP, 0, 1, Z);
        // stall-only mode
        add("C1", 0, ADD1, 0, 1, Z);
        add("C2_stall_exe", 0, ORR6, 0, 1, ex(1, 0, 1, 0, 0, 2'd0, 2'd0, 0));
        add("C3_stall_mem", 0, ORR6, 0, 1, ex(1, 0, 1, 0, 0, 2'd0, 2'd0, 0));
        add("C4", 0, ORR6, 0, 1, Z);
        add("C5", 0, NOP, 0, 1, Z);
        add("C6", 0, NOP, 0, 1, Z);
        add("C7", 0, NOP, 0, 1, Z);
        // taken branch coinciding with a load-use hazard
        add("D1", 1, LDR4, 0, 1, Z);
        add("D2_branch_hazard", 1, ADD5, 1, 1, ex(0, 1, 1, 0, 0, 2'd0, 2'd0, 0));
        add("D3", 1, NOP, 0, 1, Z);
        add("D4", 1, NOP, 0, 1, Z);
        // memory waits: two cycles (below limit), then three (timeout)
        add("E1", 1, LDR4, 0, 1, Z);
        add("E2", 1, NOP, 0, 1, Z);
        add("E3_wait", 1, NOP, 0, 0, STL);
        add("E4_wait", 1, NOP, 0, 0, STL);
        add("E5_release", 1, NOP, 0, 1, Z);
        add("E6_no_timeout", 1, NOP, 0, 1, Z);
        add("E7", 1, LDR4, 0, 1, Z);
        add("E8", 1, NOP, 0, 1, Z);
        add("E9_wait", 1, NOP, 0, 0, STL);
        add("E10_wait", 1, NOP, 0, 0, STL);
        add("E11_wait", 1, NOP, 0, 0, STL);
        add("E12_timeout", 1, NOP, 0, 1, ex(0, 0, 0, 0, 0, 2'd0, 2'd0, 1));
        add("E13_sticky", 1, NOP, 0, 1, ex(0, 0, 0, 0, 0, 2'd0, 2'd0, 1));

        bus.forwarding_en = 1'b1; bus.id_valid = 1'b0; bus.id_src = '0;
        bus.id_src_used = '0; bus.id_dest = '0; bus.id_wb_en = 1'b0;
        bus.id_mem_read = 1'b0; bus.id_mem_acc = 1'b0; bus.branch_taken = 1'b0;
        bus.mem_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_idle", {22'b0, outs()}, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) drive(vecs[i]);

`ifdef ARM_HAZARD_PERF_EN
        check("perf_hazard", bus.perf_hazard_cycles, 32'd3);
        check("perf_stall", bus.perf_mem_stall_cycles, 32'd5);
        check("perf_flush", bus.perf_flushes, 32'd1);
`endif

        // asynchronous reset while waiting on memory
        r.fwd = 1'b1; r.br = 1'b0;
        r.name = "R1"; r.ins = LDR4; r.rdy = 1'b1; r.exp = ex(0, 0, 0, 0, 0, 2'd0, 2'd0, 1);
        drive(r);
        r.name = "R2"; r.ins = NOP; drive(r);
        r.name = "R3_wait"; r.rdy = 1'b0; r.exp = ex(1, 0, 0, 1, 1, 2'd0, 2'd0, 1);
        drive(r);
        r.name = "R4_wait"; drive(r);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {22'b0, outs()}, 32'd0);
`ifdef ARM_HAZARD_PERF_EN
        check("reset_perf_hazard", bus.perf_hazard_cycles, 32'd0);
        check("reset_perf_stall", bus.perf_mem_stall_cycles, 32'd0);
        check("reset_perf_flush", bus.perf_flushes, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        r.name = "R5_slots_cleared"; r.exp = Z; drive(r);
        r.name = "R6"; r.ins = ADD1; r.rdy = 1'b1; drive(r);
        r.name = "R7"; r.ins = SUB2; drive(r);
        r.name = "R8_fwd_after_reset"; r.ins = NOP;
        r.exp = ex(0, 0, 0, 0, 0, 2'd1, 2'd0, 0);
        drive(r);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Parametrised pipeline control unit for the 5-stage ARM core. It replaces the separate combinational hazard and forwarding units and the ad-hoc freeze/flush wiring.
- It keeps a registered scoreboard of the instructions in EXE, MEM and WB. From that scoreboard it computes front-end freeze, flush, bubble insertion and per-operand forwarding selects for NUM_SRC operands.
- Unlike a fixed single-cycle data memory, it supports a variable-latency memory stage through a ready handshake, with a wait state machine and a timeout.
- It sits beside the datapath in the core top. It drives the enables and clears of the stage registers and the EXE operand muxes.

Parameters:
- REG_ADDR_W, 4, register index width.
- NUM_SRC, 2, number of source operands tracked per instruction.
- MEM_WAIT_MAX, 255, maximum MEM_WAIT cycles before mem_timeout is raised. Must be ≥1.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock; all state is updated on its rising edge.
- rst  in  1  asynchronous active-low reset.
- forwarding_en  in  1  1 = forwarding mode, 0 = stall-only mode.
- id_valid  in  1  the ID stage holds a real instruction.
- id_src  in  NUM_SRC*REG_ADDR_W  source register indices; operand k occupies bits [k*REG_ADDR_W +: REG_ADDR_W].
- id_src_used  in  NUM_SRC  per-operand read-enable.
- id_dest  in  REG_ADDR_W  destination register of the ID instruction.
- id_wb_en  in  1  the ID instruction writes the register file.
- id_mem_read  in  1  the ID instruction is a load.
- id_mem_acc  in  1  the ID instruction is a load or store.
- branch_taken  in  1  a taken branch is resolved in EXE this cycle.
- mem_ready  in  1  the data memory completes the current MEM access this cycle.
- freeze_front  out  1  hold PC and the IF/ID register.
- flush_front  out  1  clear the IF/ID register.
- bubble_exe  out  1  the ID/EXE register loads a NOP.
- stall_all  out  1  hold PC, IF/ID, ID/EXE and EXE/MEM.
- wb_bubble  out  1  the MEM/WB register loads a NOP.
- fwd_sel  out  2*NUM_SRC  per EXE operand: 0 = register file, 1 = MEM result, 2 = WB value; 3 is never driven.
- mem_timeout  out  1  sticky error flag.

Behaviour:
- Scoreboard: three slots, EXE, MEM and WB. Each slot holds {valid, dest, wb_en, mem_read, mem_acc, src[NUM_SRC], src_used}.
  - On reset every slot is invalid and all fields are 0.
- Advance (stall_all=0):
  - WB ← MEM and MEM ← EXE.
  - EXE ← ID fields when id_valid & !hazard & !branch_taken; otherwise EXE becomes invalid (a bubble).
- Hazard (combinational), for any k with id_valid & id_src_used[k]:
  - forwarding_en=0: hazard if src[k] matches a valid wb_en dest in the EXE or MEM slot.
  - forwarding_en=1: hazard only on load-use, i.e. the EXE slot is valid & mem_read & wb_en with a matching dest.
- Output equations:
  - freeze_front = stall_all | (hazard & !branch_taken).
  - bubble_exe = !stall_all & (hazard | branch_taken).
  - flush_front = branch_taken & !stall_all.
  - Taken branch plus hazard: flush wins and no freeze is applied.
- fwd_sel[k], computed from the EXE slot:
  - 1 if the MEM slot is valid & wb_en & dest==src[k];
  - else 2 if the WB slot matches the same way;
  - else 0.
  - Forced to 0 when forwarding_en=0 or src_used[k]=0.
  - MEM has priority over WB.
- FSM with states RUN and MEM_WAIT; the reset state is RUN.
  - RUN: if the MEM slot is valid & mem_acc & !mem_ready, go to MEM_WAIT and assert stall_all.
  - MEM_WAIT: stall_all=1 and wb_bubble=1 (WB is invalidated while the pipe holds). When mem_ready=1, stall_all=0 that cycle and the pipe advances; next state is RUN.
  - mem_ready=1 in the first MEM cycle means zero wait states and no stall.
  - Combinationally, stall_all = MEM slot valid & mem_acc & !mem_ready.
- Wait counter:
  - Cleared on entry to MEM_WAIT and increments each MEM_WAIT cycle.
  - When it reaches MEM_WAIT_MAX, mem_timeout is set. It stays set until reset, and the FSM keeps waiting.
- Branch during a memory stall: branch_taken is held frozen in EXE, so the flush takes effect in the cycle the stall releases.
- Reset mid-operation (asynchronous): slots invalid, FSM in RUN, counters 0, and every output deasserted on the same edge.

Optional Feature:
- Macro ARM_HAZARD_PERF_EN.
- When defined, add three outputs, each CNT_W wide and saturating at all-ones:
  - perf_hazard_cycles, incremented when hazard & !branch_taken & !stall_all;
  - perf_mem_stall_cycles, incremented when stall_all;
  - perf_flushes, incremented when flush_front.
  - All three reset to 0.
- When not defined, these ports and their logic are absent.

Decomposition:
- Shared package arm_pipe_pkg holds:
  - fwd_sel encodings FWD_RF=0, FWD_MEM=1, FWD_WB=2;
  - the scoreboard slot struct typedef;
  - FSM state enum {RUN, MEM_WAIT}.
- One sub-module: pipe_dep_cmp, which compares one source against one slot. It is instantiated per operand and per slot.

Test Plan:
- forwarding_en=1, ADD R1 then SUB R2,R1,R3 back-to-back → no stall; the SUB in EXE sees fwd_sel[1:0]=1. One cycle later a dependent instruction sees fwd_sel=2.
- forwarding_en=1, LDR R4 followed by ADD R5,R4,R4 → exactly 1 cycle of freeze_front and bubble_exe, then fwd_sel=2 for both operands.
- forwarding_en=0, ADD R1 then ORR R6,R1,#1 → exactly 2 freeze cycles and fwd_sel=0 throughout.
- LDR with mem_ready held low for 3 cycles → stall_all high for 3 cycles, 3 WB bubbles. With MEM_WAIT_MAX=2, mem_timeout sets and stays set after mem_ready returns.
- branch_taken in the same cycle as a load-use hazard → flush_front=1, bubble_exe=1, freeze_front=0.
- Assert rst low while in MEM_WAIT → FSM in RUN, all outputs 0 and slots invalid immediately. With ARM_HAZARD_PERF_EN, all counters read 0.
